// File: rtl/memory_requester_pkg.sv
// Shared memory-side types and constants for the PDP-8 memory requester:
// word width, read-type encodings, command and FSM state enums, auto-index range.
package memory_requester_pkg;

  typedef logic [11:0] word;

  localparam logic DATA_READ         = 1'b0;
  localparam logic INSTRUCTION_FETCH = 1'b1;

  localparam word AUTO_INDEX_LO = 12'o0010;
  localparam word AUTO_INDEX_HI = 12'o0017;

  typedef enum logic [1:0] {
    CMD_FETCH = 2'd0,
    CMD_READ  = 2'd1,
    CMD_WRITE = 2'd2,
    CMD_EA    = 2'd3
  } mem_cmd_t;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_IF_REQ   = 4'd1,
    ST_IF_WAIT  = 4'd2,
    ST_IND_REQ  = 4'd3,
    ST_IND_WAIT = 4'd4,
    ST_AUTO_WR  = 4'd5,
    ST_OP_REQ   = 4'd6,
    ST_OP_WAIT  = 4'd7,
    ST_OP_WR    = 4'd8,
    ST_DONE     = 4'd9
  } req_state_t;

  // Locations 0010-0017 increment their contents when used as an indirect pointer.
  function automatic logic is_auto_index(input word ea);
    return (ea >= AUTO_INDEX_LO) && (ea <= AUTO_INDEX_HI);
  endfunction

endpackage

// File: rtl/memory_requester_if.sv
// Command/response and memory-controller pins of the memory requester.
// master: the requester itself; slave: the CPU core plus memory controller side.
interface memory_requester_if;
  import memory_requester_pkg::*;

  logic     cmd_valid;
  logic     cmd_ready;
  mem_cmd_t cmd_op;
  word      cmd_pc;
  word      cmd_instr;
  word      cmd_wdata;

  logic     rsp_valid;
  word      rsp_data;
  word      rsp_ea;

  word      mem_address;
  word      mem_write_data;
  logic     mem_read_enable;
  logic     mem_read_type;
  logic     mem_write_enable;
  word      mem_read_data;

  modport master (
    input  cmd_valid, cmd_op, cmd_pc, cmd_instr, cmd_wdata, mem_read_data,
    output cmd_ready, rsp_valid, rsp_data, rsp_ea,
           mem_address, mem_write_data, mem_read_enable, mem_read_type, mem_write_enable
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_pc, cmd_instr, cmd_wdata, mem_read_data,
    input  cmd_ready, rsp_valid, rsp_data, rsp_ea,
           mem_address, mem_write_data, mem_read_enable, mem_read_type, mem_write_enable
  );

endinterface

// File: rtl/memory_requester_ea_calc.sv
// Direct effective address of a memory-reference instruction (page zero or
// current page) and detection of the auto-index pointer window.
module memory_requester_ea_calc
  import memory_requester_pkg::*;
(
  input  logic       page_sel,
  input  logic [6:0] offset,
  input  logic [4:0] pc_page,
  output word        ea,
  output logic       auto_idx
);

  // Page select picks between page zero and the page holding the instruction.
  always_comb begin
    ea       = page_sel ? {pc_page, offset} : {5'b0, offset};
    auto_idx = is_auto_index(ea);
  end

endmodule

// File: rtl/memory_requester.sv
// PDP-8 memory requester: one command at a time, resolves effective addresses
// (page, indirection, auto-index write-back), pulses the controller pins and
// returns one response per command.
//
// state       | meaning
// ------------+--------------------------------------------------------------
// ST_IDLE     | ready for a command
// ST_IF_REQ   | instruction-fetch read pulse at cmd_pc
// ST_IF_WAIT  | capture fetched instruction
// ST_IND_REQ  | data read pulse for the indirect pointer
// ST_IND_WAIT | capture pointer, pick auto-index or operand step
// ST_AUTO_WR  | write incremented pointer back to its auto-index location
// ST_OP_REQ   | data read pulse at the final EA
// ST_OP_WAIT  | capture operand
// ST_OP_WR    | data write pulse of cmd_wdata at the final EA
// ST_DONE     | one-cycle response strobe
module memory_requester
  import memory_requester_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  memory_requester_if.master  bus
);

  req_state_t state_q, state_d;
  mem_cmd_t   op_q, op_sel;
  word        wdata_q, wd_sel;
  word        ea_q, ea_d, tgt;
  logic       auto_q;
  logic       ready_q;
  logic       accept;
  logic       to_operand;

  word        addr_q, addr_d;
  word        mwd_q, mwd_d;
  word        data_d;
  logic       rd_en_q, wr_en_q, rd_type_q;
  logic       rsp_valid_q;
  word        rsp_data_q, rsp_ea_q;

  word        ea_direct;
  logic       auto_direct;

  // Opcode bits select the CPU operation, not the memory access.
  logic unused_opcode;
  assign unused_opcode = ^bus.cmd_instr[11:9];

  memory_requester_ea_calc u_ea_calc (
    .page_sel (bus.cmd_instr[7]),
    .offset   (bus.cmd_instr[6:0]),
    .pc_page  (bus.cmd_pc[11:7]),
    .ea       (ea_direct),
    .auto_idx (auto_direct)
  );

  assign accept = (state_q == ST_IDLE) && ready_q && bus.cmd_valid;
  // While idle the live command drives the operand step so direct commands
  // issue their first pulse in the cycle right after acceptance.
  assign op_sel = (state_q == ST_IDLE) ? bus.cmd_op    : op_q;
  assign wd_sel = (state_q == ST_IDLE) ? bus.cmd_wdata : wdata_q;

  // Next state, next EA and the pin values to present during the next cycle.
  always_comb begin
    state_d    = state_q;
    ea_d       = ea_q;
    addr_d     = addr_q;
    mwd_d      = mwd_q;
    data_d     = '0;
    tgt        = ea_q;
    to_operand = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (bus.cmd_op == CMD_FETCH) begin
            state_d = ST_IF_REQ;
            ea_d    = bus.cmd_pc;
            addr_d  = bus.cmd_pc;
          end else if (bus.cmd_instr[8]) begin
            state_d = ST_IND_REQ;
            ea_d    = ea_direct;
            addr_d  = ea_direct;
          end else begin
            ea_d       = ea_direct;
            tgt        = ea_direct;
            to_operand = 1'b1;
          end
        end
      end
      ST_IF_REQ:  state_d = ST_IF_WAIT;
      ST_IND_REQ: state_d = ST_IND_WAIT;
      ST_OP_REQ:  state_d = ST_OP_WAIT;
      ST_IF_WAIT, ST_OP_WAIT: begin
        data_d  = bus.mem_read_data;
        state_d = ST_DONE;
      end
      ST_IND_WAIT: begin
        if (auto_q) begin
          // Address stays on the pointer location for the write-back.
          ea_d    = bus.mem_read_data + 12'd1;
          mwd_d   = bus.mem_read_data + 12'd1;
          state_d = ST_AUTO_WR;
        end else begin
          ea_d       = bus.mem_read_data;
          tgt        = bus.mem_read_data;
          to_operand = 1'b1;
        end
      end
      ST_AUTO_WR: begin
        tgt        = ea_q;
        to_operand = 1'b1;
      end
      ST_OP_WR:   state_d = ST_DONE;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
    if (to_operand) begin
      unique case (op_sel)
        CMD_READ: begin
          state_d = ST_OP_REQ;
          addr_d  = tgt;
        end
        CMD_WRITE: begin
          state_d = ST_OP_WR;
          addr_d  = tgt;
          mwd_d   = wd_sel;
        end
        default: state_d = ST_DONE;
      endcase
    end
  end

  // State register and registered pins; every pin follows the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ready_q     <= 1'b0;
      ea_q        <= '0;
      addr_q      <= '0;
      mwd_q       <= '0;
      rd_en_q     <= 1'b0;
      wr_en_q     <= 1'b0;
      rd_type_q   <= INSTRUCTION_FETCH;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_ea_q    <= '0;
    end else begin
      state_q     <= state_d;
      ready_q     <= (state_d == ST_IDLE);
      ea_q        <= ea_d;
      addr_q      <= addr_d;
      mwd_q       <= mwd_d;
      rd_en_q     <= (state_d == ST_IF_REQ) || (state_d == ST_IND_REQ) || (state_d == ST_OP_REQ);
      wr_en_q     <= (state_d == ST_AUTO_WR) || (state_d == ST_OP_WR);
      rd_type_q   <= (state_d == ST_IF_REQ) ? INSTRUCTION_FETCH : DATA_READ;
      rsp_valid_q <= (state_d == ST_DONE);
      if (state_d == ST_DONE) begin
        rsp_data_q <= data_d;
        rsp_ea_q   <= ea_d;
      end
    end
  end

  // Command fields latched at acceptance for the later steps.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q    <= CMD_FETCH;
      wdata_q <= '0;
      auto_q  <= 1'b0;
    end else if (accept) begin
      op_q    <= bus.cmd_op;
      wdata_q <= bus.cmd_wdata;
      auto_q  <= bus.cmd_instr[8] && auto_direct;
    end
  end

  assign bus.cmd_ready        = ready_q;
  assign bus.rsp_valid        = rsp_valid_q;
  assign bus.rsp_data         = rsp_data_q;
  assign bus.rsp_ea           = rsp_ea_q;
  assign bus.mem_address      = addr_q;
  assign bus.mem_write_data   = mwd_q;
  assign bus.mem_read_enable  = rd_en_q;
  assign bus.mem_write_enable = wr_en_q;
  assign bus.mem_read_type    = rd_type_q;

endmodule

// File: tb/tb_memory_requester.sv
// Bench for memory_requester: vector table with a pulse/response scoreboard,
// a small registered memory model, plus busy, hold and abort sequences.
module tb_memory_requester;
  import memory_requester_pkg::*;

  localparam logic [1:0] K_IF = 2'd0;
  localparam logic [1:0] K_DR = 2'd1;
  localparam logic [1:0] K_DW = 2'd2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  memory_requester_if bus ();

  memory_requester dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  // memory model: read data registered one cycle after the read pulse
  word  mem [4096];
  word  rd_q = '0;
  logic pl_en = 1'b0;
  word  pl_a = '0;
  word  pl_d = '0;

  always @(posedge clk) begin
    if (bus.mem_read_enable) rd_q <= mem[bus.mem_address];
    if (bus.mem_write_enable) mem[bus.mem_address] <= bus.mem_write_data;
    if (pl_en) mem[pl_a] <= pl_d;
  end
  assign bus.mem_read_data = rd_q;

  typedef struct packed {
    logic [1:0] kind;
    word        addr;
    word        data;
  } pulse_t;

  typedef struct packed {
    word         data;
    word         ea;
    logic [31:0] cyc;
  } rsp_t;

  pulse_t pq[$];
  rsp_t   rq[$];

  typedef struct {
    mem_cmd_t        op;
    word             pc;
    word             instr;
    word             wdata;
    int              npre;
    word             pre_a0, pre_d0, pre_a1, pre_d1;
    word             exp_data;
    word             exp_ea;
    int              exp_lat;
    int              np;
    logic [3:0][1:0] pk;
    logic [3:0][11:0] pa;
    logic [3:0][11:0] pd;
    logic            chk;
    word             ca, cd;
  } vec_t;

  vec_t vt [16];
  int   nv = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0o required=%0o (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // scoreboard: compare every enable pulse and every response as it appears
  always @(negedge clk) begin
    if (bus.mem_read_enable || bus.mem_write_enable) begin
      check("enable_exclusive", {31'd0, bus.mem_read_enable & bus.mem_write_enable}, 32'd0);
      if (pq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse actual re=%0b we=%0b addr=%0o required none (cycle %0d)",
                 bus.mem_read_enable, bus.mem_write_enable, bus.mem_address, cyc);
      end else begin
        check("pulse_kind", bus.mem_write_enable ? K_DW :
              (bus.mem_read_type == INSTRUCTION_FETCH ? K_IF : K_DR), pq[0].kind);
        check("pulse_addr", bus.mem_address, pq[0].addr);
        check("pulse_wdata", bus.mem_write_enable ? bus.mem_write_data : 12'd0, pq[0].data);
        pq.delete(0);
      end
    end
    if (bus.rsp_valid) begin
      if (rq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp actual ea=%0o data=%0o required none (cycle %0d)",
                 bus.rsp_ea, bus.rsp_data, cyc);
      end else begin
        check("rsp_data", bus.rsp_data, rq[0].data);
        check("rsp_ea", bus.rsp_ea, rq[0].ea);
        check("rsp_cycle", cyc, rq[0].cyc);
        rq.delete(0);
      end
    end
  end

  task automatic add(input mem_cmd_t op, input word pc, input word instr, input word wd,
                     input word data, input word ea, input int lat);
    vt[nv].op = op;  vt[nv].pc = pc;  vt[nv].instr = instr;  vt[nv].wdata = wd;
    vt[nv].exp_data = data;  vt[nv].exp_ea = ea;  vt[nv].exp_lat = lat;
    vt[nv].npre = 0;  vt[nv].np = 0;  vt[nv].chk = 1'b0;
    vt[nv].ca = '0;  vt[nv].cd = '0;  vt[nv].pk = '0;  vt[nv].pa = '0;  vt[nv].pd = '0;
    vt[nv].pre_a0 = '0;  vt[nv].pre_d0 = '0;  vt[nv].pre_a1 = '0;  vt[nv].pre_d1 = '0;
    nv++;
  endtask

  task automatic pul(input logic [1:0] k, input word a, input word d);
    vt[nv-1].pk[vt[nv-1].np] = k;
    vt[nv-1].pa[vt[nv-1].np] = a;
    vt[nv-1].pd[vt[nv-1].np] = d;
    vt[nv-1].np++;
  endtask

  task automatic pre(input word a, input word d);
    if (vt[nv-1].npre == 0) begin
      vt[nv-1].pre_a0 = a;  vt[nv-1].pre_d0 = d;
    end else begin
      vt[nv-1].pre_a1 = a;  vt[nv-1].pre_d1 = d;
    end
    vt[nv-1].npre++;
  endtask

  task automatic memchk(input word a, input word d);
    vt[nv-1].chk = 1'b1;  vt[nv-1].ca = a;  vt[nv-1].cd = d;
  endtask

  task automatic preload(input word a, input word d);
    pl_a = a;  pl_d = d;  pl_en = 1'b1;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic preload_vec(input vec_t v);
    if (v.npre > 0) preload(v.pre_a0, v.pre_d0);
    if (v.npre > 1) preload(v.pre_a1, v.pre_d1);
  endtask

  // Present a command from a negedge; expectations are queued at acceptance.
  task automatic issue(input vec_t v, input bit hold, output int c0);
    bus.cmd_op = v.op;  bus.cmd_pc = v.pc;  bus.cmd_instr = v.instr;  bus.cmd_wdata = v.wdata;
    bus.cmd_valid = 1'b1;
    c0 = -1;
    for (int i = 0; i < 60 && c0 < 0; i++) begin
      if (bus.cmd_ready) begin
        c0 = cyc;
        for (int k = 0; k < v.np; k++) pq.push_back({v.pk[k], v.pa[k], v.pd[k]});
        if (v.exp_lat > 0) rq.push_back({v.exp_data, v.exp_ea, 32'(c0 + v.exp_lat)});
      end
      @(negedge clk);
    end
    if (!hold) bus.cmd_valid = 1'b0;
    if (c0 < 0) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout actual=not_accepted required=accepted");
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && (rq.size() != 0 || pq.size() != 0); i++) @(negedge clk);
    if (rq.size() != 0 || pq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual rsp_left=%0d pulse_left=%0d required 0", rq.size(), pq.size());
      rq.delete();
      pq.delete();
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ready"}, {31'd0, bus.cmd_ready}, 32'd0);
    check({tag, "_rsp_valid"}, {31'd0, bus.rsp_valid}, 32'd0);
    check({tag, "_re"}, {31'd0, bus.mem_read_enable}, 32'd0);
    check({tag, "_we"}, {31'd0, bus.mem_write_enable}, 32'd0);
    check({tag, "_addr"}, bus.mem_address, 32'd0);
    check({tag, "_wdata"}, bus.mem_write_data, 32'd0);
    check({tag, "_rsp_data"}, bus.rsp_data, 32'd0);
    check({tag, "_rsp_ea"}, bus.rsp_ea, 32'd0);
    check({tag, "_rd_type"}, {31'd0, bus.mem_read_type}, {31'd0, INSTRUCTION_FETCH});
  endtask

  initial begin
    int   c0, c1;
    vec_t va, vb, ab;

    bus.cmd_valid = 1'b0;  bus.cmd_op = CMD_FETCH;
    bus.cmd_pc = '0;  bus.cmd_instr = '0;  bus.cmd_wdata = '0;

    // op, pc, instr, wdata, exp data, exp ea, latency
    add(CMD_FETCH, 12'o0200, 12'o0000, 12'o0000, 12'o1234, 12'o0200, 3);
    pre(12'o0200, 12'o1234);  pul(K_IF, 12'o0200, 12'o0);
    add(CMD_READ,  12'o0000, 12'o1045, 12'o0000, 12'o0777, 12'o0045, 3);
    pre(12'o0045, 12'o0777);  pul(K_DR, 12'o0045, 12'o0);
    add(CMD_READ,  12'o0400, 12'o1720, 12'o0000, 12'o0042, 12'o3000, 5);
    pre(12'o0520, 12'o3000);  pre(12'o3000, 12'o0042);
    pul(K_DR, 12'o0520, 12'o0);  pul(K_DR, 12'o3000, 12'o0);
    add(CMD_READ,  12'o0000, 12'o1410, 12'o0000, 12'o0555, 12'o0000, 6);
    pre(12'o0010, 12'o7777);  pre(12'o0000, 12'o0555);
    pul(K_DR, 12'o0010, 12'o0);  pul(K_DW, 12'o0010, 12'o0000);  pul(K_DR, 12'o0000, 12'o0);
    memchk(12'o0010, 12'o0000);
    add(CMD_WRITE, 12'o0000, 12'o3050, 12'o4321, 12'o0000, 12'o0050, 2);
    pul(K_DW, 12'o0050, 12'o4321);  memchk(12'o0050, 12'o4321);
    add(CMD_EA,    12'o1234, 12'o0277, 12'o0000, 12'o0000, 12'o1277, 1);
    add(CMD_EA,    12'o0000, 12'o0417, 12'o0000, 12'o0000, 12'o2346, 4);
    pre(12'o0017, 12'o2345);
    pul(K_DR, 12'o0017, 12'o0);  pul(K_DW, 12'o0017, 12'o2346);  memchk(12'o0017, 12'o2346);
    add(CMD_WRITE, 12'o0000, 12'o3407, 12'o7070, 12'o0000, 12'o0100, 4);
    pre(12'o0007, 12'o0100);
    pul(K_DR, 12'o0007, 12'o0);  pul(K_DW, 12'o0100, 12'o7070);  memchk(12'o0100, 12'o7070);
    add(CMD_READ,  12'o0000, 12'o1420, 12'o0000, 12'o1111, 12'o0300, 5);
    pre(12'o0020, 12'o0300);  pre(12'o0300, 12'o1111);
    pul(K_DR, 12'o0020, 12'o0);  pul(K_DR, 12'o0300, 12'o0);
    add(CMD_WRITE, 12'o0000, 12'o3410, 12'o6543, 12'o0000, 12'o0001, 5);
    pre(12'o0010, 12'o0000);
    pul(K_DR, 12'o0010, 12'o0);  pul(K_DW, 12'o0010, 12'o0001);  pul(K_DW, 12'o0001, 12'o6543);
    memchk(12'o0001, 12'o6543);
    add(CMD_READ,  12'o0400, 12'o1520, 12'o0000, 12'o7654, 12'o0456, 5);
    pre(12'o0120, 12'o0456);  pre(12'o0456, 12'o7654);
    pul(K_DR, 12'o0120, 12'o0);  pul(K_DR, 12'o0456, 12'o0);
    add(CMD_FETCH, 12'o7777, 12'o0000, 12'o0000, 12'o0001, 12'o7777, 3);
    pre(12'o7777, 12'o0001);  pul(K_IF, 12'o7777, 12'o0);
    add(CMD_EA,    12'o7777, 12'o0200, 12'o0000, 12'o0000, 12'o7600, 1);

    @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_ready", {31'd0, bus.cmd_ready}, 32'd1);
    check("post_reset_rd_type", {31'd0, bus.mem_read_type}, {31'd0, DATA_READ});

    for (int i = 0; i < nv; i++) begin
      preload_vec(vt[i]);
      issue(vt[i], 1'b0, c0);
      drain();
      if (vt[i].chk) check("mem_after", mem[vt[i].ca], vt[i].cd);
    end

    // second command held valid while busy: accepted the cycle after DONE
    va = vt[0];
    vb = vt[1];
    preload_vec(va);
    preload_vec(vb);
    issue(va, 1'b1, c0);
    issue(vb, 1'b0, c1);
    check("busy_accept_cycle", c1, c0 + va.exp_lat + 1);
    drain();

    // response fields hold after the strobe
    repeat (3) @(negedge clk);
    check("hold_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("hold_rsp_ea", bus.rsp_ea, 12'o0045);
    check("hold_rsp_data", bus.rsp_data, 12'o0777);

    // reset during IND_WAIT of an indirect read: only the pointer read happens
    ab = vt[8];
    ab.np = 1;
    ab.exp_lat = 0;
    preload_vec(ab);
    issue(ab, 1'b0, c0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_values("abort");
    rst = 1'b0;
    @(negedge clk);
    check("abort_ready_after", {31'd0, bus.cmd_ready}, 32'd1);
    repeat (8) @(negedge clk);
    check("abort_pulses_left", pq.size(), 32'd0);
    check("abort_rsp_left", rq.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
